// File: rtl/prog_run_sequencer.sv
// Run controller: launches each enabled benchmark program in ascending order,
// times its RUN phase against TIMEOUT and reports one result per program.
module prog_run_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             go,
  input  logic             abort,
  input  logic [2:0]       prog_mask,
  input  logic             core_done,
  output logic             start,
  output logic [1:0]       problem,
  output logic             busy,
  output logic             batch_done,
  output logic             result_valid,
  output logic [1:0]       result_prog,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LAUNCH, S_SETTLE, S_RUN, S_REPORT, S_FINISH
  } state_t;

  state_t           state;
  logic [2:0]       pending;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       low_idx;

  assign cnt_inc = cnt + CNT_W'(1);

  // Lowest pending program; never yields 2'b11.
  always_comb begin
    low_idx = 2'd2;
    if (pending[0])      low_idx = 2'd0;
    else if (pending[1]) low_idx = 2'd1;
  end

  // Single-process FSM; start, pulses and result fields are all flop outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= S_IDLE;
      pending        <= 3'b000;
      cnt            <= '0;
      start          <= 1'b0;
      problem        <= 2'd0;
      busy           <= 1'b0;
      batch_done     <= 1'b0;
      result_valid   <= 1'b0;
      result_prog    <= 2'd0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      start        <= 1'b0;
      batch_done   <= 1'b0;
      result_valid <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              pending     <= prog_mask;
              timeout_err <= 1'b0;
              busy        <= 1'b1;
              state       <= S_SELECT;
            end
          end
          S_SELECT: begin
            if (pending != 3'b000) begin
              problem <= low_idx;
              pending <= pending & (pending - 3'd1);
              start   <= 1'b1;
              state   <= S_LAUNCH;
            end else begin
              batch_done <= 1'b1;
              state      <= S_FINISH;
            end
          end
          S_LAUNCH: state <= S_SETTLE;
          // Done is ignored here so a flag left over from the last program is never counted.
          S_SETTLE: begin
            cnt   <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            cnt <= cnt_inc;
            if (core_done) begin
              result_valid   <= 1'b1;
              result_prog    <= problem;
              result_cycles  <= cnt_inc;
              result_timeout <= 1'b0;
              state          <= S_REPORT;
            end else if (cnt_inc == TIMEOUT_C) begin
              result_valid   <= 1'b1;
              result_prog    <= problem;
              result_cycles  <= cnt_inc;
              result_timeout <= 1'b1;
              timeout_err    <= 1'b1;
              state          <= S_REPORT;
            end
          end
          S_REPORT: state <= S_SELECT;
          S_FINISH: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Directed bench for prog_run_sequencer: a default-TIMEOUT instance driven by a
// latency-based core model, and a TIMEOUT=20 instance with done stuck low.
module tb_prog_run_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic       go_a, go_b, abort, done_b;
  logic [2:0] mask;
  logic       core_done_a;

  logic        start_a, busy_a, bd_a, rv_a, rt_a, te_a;
  logic [1:0]  problem_a, rp_a;
  logic [15:0] rc_a;
  logic        start_b, busy_b, bd_b, rv_b, rt_b, te_b;
  logic [1:0]  problem_b, rp_b;
  logic [15:0] rc_b;

  prog_run_sequencer dut_a (
    .Clk(Clk), .Reset(Reset), .go(go_a), .abort(abort), .prog_mask(mask),
    .core_done(core_done_a), .start(start_a), .problem(problem_a), .busy(busy_a),
    .batch_done(bd_a), .result_valid(rv_a), .result_prog(rp_a),
    .result_cycles(rc_a), .result_timeout(rt_a), .timeout_err(te_a)
  );

  prog_run_sequencer #(.CNT_W(16), .TIMEOUT(20)) dut_b (
    .Clk(Clk), .Reset(Reset), .go(go_b), .abort(abort), .prog_mask(mask),
    .core_done(done_b), .start(start_b), .problem(problem_b), .busy(busy_b),
    .batch_done(bd_b), .result_valid(rv_b), .result_prog(rp_b),
    .result_cycles(rc_b), .result_timeout(rt_b), .timeout_err(te_b)
  );

  // Core model: done rises lat cycles after the start pulse, cleared by the next start.
  int core_cnt = 0;
  int lat0 = 50, lat1 = 50, lat2 = 50;
  int cur_lat;
  logic force_hi = 1'b0;
  always @(posedge Clk) begin
    if (start_a) core_cnt <= 1;
    else if (core_cnt != 0) core_cnt <= core_cnt + 1;
  end
  always_comb cur_lat = (problem_a == 2'd0) ? lat0 : (problem_a == 2'd1) ? lat1 : lat2;
  assign core_done_a = force_hi || (core_cnt != 0 && core_cnt >= cur_lat);

  // Event monitor sampled on the falling edge.
  int cyc = 0, n_start_a = 0, n_res_a = 0, n_bd_a = 0, n_rv_b = 0, n_bd_b = 0;
  int last_rv_cyc = 0, last_bd_cyc = 0;
  int res_cyc [16];
  int res_prog [16];
  int res_to [16];
  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (start_a) n_start_a <= n_start_a + 1;
    if (rv_a) begin
      if (n_res_a < 16) begin
        res_cyc[n_res_a]  <= int'(rc_a);
        res_prog[n_res_a] <= int'(rp_a);
        res_to[n_res_a]   <= int'(rt_a);
      end
      n_res_a     <= n_res_a + 1;
      last_rv_cyc <= cyc;
    end
    if (bd_a) begin
      n_bd_a      <= n_bd_a + 1;
      last_bd_cyc <= cyc;
    end
    if (rv_b) n_rv_b <= n_rv_b + 1;
    if (bd_b) n_bd_b <= n_bd_b + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_bd(input bit use_b, input int base, input int limit, output bit ok);
    int t = 0;
    while (((use_b ? n_bd_b : n_bd_a) == base) && t < limit) begin
      tick();
      t++;
    end
    ok = (t < limit);
  endtask

  task automatic test_reset();
    Reset = 1'b1; go_a = 0; go_b = 0; abort = 0; done_b = 0; mask = 3'b000;
    tick(); tick();
    checks++;
    if ({start_a, busy_a, bd_a, rv_a, rt_a, te_a, problem_a, rp_a, rc_a} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {start_a, busy_a, bd_a, rv_a, rt_a, te_a, problem_a, rp_a, rc_a});
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b%b expected 00", busy_a, busy_b);
    end
  endtask

  task automatic test_single();
    int s0 = n_start_a, r0 = n_res_a, b0 = n_bd_a;
    bit ok;
    lat0 = 50; mask = 3'b001; go_a = 1; tick(); go_a = 0;
    checks++;
    if (start_a !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b expected 0", start_a); end
    tick();
    checks++;
    if (start_a !== 1'b1) begin errors++; $display("FAIL single_start_launch: got %b expected 1", start_a); end
    wait_bd(1'b0, b0, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wait: got no batch_done expected batch_done"); end
    checks++;
    if (n_start_a - s0 != 1 || n_res_a - r0 != 1) begin
      errors++; $display("FAIL single_counts: got starts=%0d results=%0d expected 1 1", n_start_a - s0, n_res_a - r0);
    end
    checks++;
    if (res_cyc[r0] != 49 || res_prog[r0] != 0 || res_to[r0] != 0) begin
      errors++; $display("FAIL single_result: got cyc=%0d prog=%0d to=%0d expected 49 0 0", res_cyc[r0], res_prog[r0], res_to[r0]);
    end
    checks++;
    if (last_bd_cyc - last_rv_cyc != 2) begin
      errors++; $display("FAIL single_bd_gap: got %0d expected 2", last_bd_cyc - last_rv_cyc);
    end
    checks++;
    if (te_a !== 1'b0 || problem_a !== 2'd0) begin
      errors++; $display("FAIL single_flags: got te=%b prob=%0d expected 0 0", te_a, problem_a);
    end
    tick();
  endtask

  task automatic test_full_batch();
    int s0 = n_start_a, r0 = n_res_a, b0 = n_bd_a;
    int exp_c [3] = '{118, 105, 81};
    bit ok;
    lat0 = 119; lat1 = 106; lat2 = 82; mask = 3'b111;
    go_a = 1; tick(); go_a = 0;
    wait_bd(1'b0, b0, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_wait: got no batch_done expected batch_done"); end
    checks++;
    if (n_start_a - s0 != 3 || n_res_a - r0 != 3) begin
      errors++; $display("FAIL full_counts: got starts=%0d results=%0d expected 3 3", n_start_a - s0, n_res_a - r0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res_prog[r0+i] != i || res_cyc[r0+i] != exp_c[i] || res_to[r0+i] != 0) begin
        errors++;
        $display("FAIL full_result%0d: got prog=%0d cyc=%0d to=%0d expected %0d %0d 0",
                 i, res_prog[r0+i], res_cyc[r0+i], res_to[r0+i], i, exp_c[i]);
      end
    end
    tick(); tick();
    checks++;
    if (n_bd_a - b0 != 1) begin errors++; $display("FAIL full_bd_count: got %0d expected 1", n_bd_a - b0); end
  endtask

  task automatic test_timeout();
    int v0 = n_rv_b, b0 = n_bd_b;
    bit ok;
    done_b = 0; mask = 3'b010; go_b = 1; tick(); go_b = 0;
    wait_bd(1'b1, b0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_wait: got no batch_done expected batch_done"); end
    checks++;
    if (rc_b !== 16'd20 || rt_b !== 1'b1 || rp_b !== 2'd1 || n_rv_b - v0 != 1) begin
      errors++; $display("FAIL to_result: got cyc=%0d to=%b prog=%0d n=%0d expected 20 1 1 1", rc_b, rt_b, rp_b, n_rv_b - v0);
    end
    repeat (5) tick();
    checks++;
    if (te_b !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", te_b); end
    mask = 3'b000; go_b = 1; tick(); go_b = 0;
    checks++;
    if (te_b !== 1'b0) begin errors++; $display("FAIL to_clear_on_go: got %b expected 0", te_b); end
    repeat (3) tick();
  endtask

  task automatic test_stale_and_empty();
    int s0, r0 = n_res_a, b0 = n_bd_a, v0;
    bit ok;
    force_hi = 1'b1; mask = 3'b100; go_a = 1; tick(); go_a = 0;
    wait_bd(1'b0, b0, 100, ok);
    force_hi = 1'b0;
    checks++;
    if (!ok || res_cyc[r0] != 1 || res_prog[r0] != 2 || res_to[r0] != 0) begin
      errors++; $display("FAIL stale_result: got ok=%0d cyc=%0d prog=%0d to=%0d expected 1 1 2 0", ok, res_cyc[r0], res_prog[r0], res_to[r0]);
    end
    tick();
    s0 = n_start_a; b0 = n_bd_a; v0 = n_res_a;
    mask = 3'b000; go_a = 1; tick(); go_a = 0;
    checks++;
    if (bd_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL empty_select: got bd=%b busy=%b expected 0 1", bd_a, busy_a); end
    tick();
    checks++;
    if (bd_a !== 1'b1) begin errors++; $display("FAIL empty_bd_time: got %b expected 1", bd_a); end
    tick();
    checks++;
    if (bd_a !== 1'b0 || busy_a !== 1'b0 || n_start_a != s0 || n_res_a != v0 || n_bd_a - b0 != 1) begin
      errors++; $display("FAIL empty_after: got bd=%b busy=%b starts=%0d res=%0d bds=%0d expected 0 0 0 0 1",
                         bd_a, busy_a, n_start_a - s0, n_res_a - v0, n_bd_a - b0);
    end
  endtask

  task automatic test_abort_ignored_go();
    int s0 = n_start_a, r0 = n_res_a, b0 = n_bd_a, t = 0;
    lat0 = 500; mask = 3'b001; go_a = 1; tick(); go_a = 0;
    while (!start_a && t < 10) begin tick(); t++; end
    checks++;
    if (!start_a) begin errors++; $display("FAIL abort_launch: got no start expected start"); end
    tick(); tick();
    tick(); tick();
    go_a = 1; tick(); go_a = 0;
    repeat (6) tick();
    abort = 1; tick(); abort = 0;
    checks++;
    if (busy_a !== 1'b0 || rv_a !== 1'b0 || bd_a !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b rv=%b bd=%b expected 0 0 0", busy_a, rv_a, bd_a);
    end
    repeat (5) tick();
    checks++;
    if (busy_a !== 1'b0 || n_start_a - s0 != 1 || n_res_a != r0 || n_bd_a != b0) begin
      errors++; $display("FAIL abort_quiet: got busy=%b starts=%0d res=%0d bds=%0d expected 0 1 0 0",
                         busy_a, n_start_a - s0, n_res_a - r0, n_bd_a - b0);
    end
  endtask

  task automatic test_async_reset();
    int r0, b0, t = 0;
    bit ok;
    lat2 = 500; mask = 3'b100; go_a = 1; tick(); go_a = 0;
    while (!start_a && t < 10) begin tick(); t++; end
    repeat (10) tick();
    @(negedge Clk); #3 Reset = 1'b1; #1;
    checks++;
    if ({start_a, busy_a, bd_a, rv_a, rt_a, te_a, problem_a, rp_a, rc_a} !== 24'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {start_a, busy_a, bd_a, rv_a, rt_a, te_a, problem_a, rp_a, rc_a});
    end
    tick(); Reset = 1'b0; tick();
    r0 = n_res_a; b0 = n_bd_a;
    lat0 = 30; mask = 3'b001; go_a = 1; tick(); go_a = 0;
    wait_bd(1'b0, b0, 200, ok);
    checks++;
    if (!ok || res_cyc[r0] != 29 || res_prog[r0] != 0 || n_res_a - r0 != 1) begin
      errors++; $display("FAIL reset_rerun: got ok=%0d cyc=%0d prog=%0d n=%0d expected 1 29 0 1", ok, res_cyc[r0], res_prog[r0], n_res_a - r0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_batch();
    test_timeout();
    test_stale_and_empty();
    test_abort_ignored_go();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_run_sequencer.md
# prog_run_sequencer

Run controller that sequences the core's three benchmark programs (problem codes 0, 1, 2) through the program counter block. On a `go` request it selects each enabled program in ascending order and pulses the core's `start`. It then waits for the PC's done flag and reports a per-program cycle count and timeout status. It sits between the testbench/host interface and the core's `start`/`problem` inputs and `pc_done_flag` output.

## Interface

**Parameters**
- `CNT_W`, 16: width of the run-cycle counter and `result_cycles`.
- `TIMEOUT`, 4000: maximum RUN cycles per program. Legal range is 1 to 2^CNT_W-1.

**Ports**
- `Clk` (in, 1): clock. All state changes on the rising edge.
- `Reset` (in, 1): reset, asynchronous, active-high.
- `go` (in, 1): start a batch. Sampled only in IDLE.
- `abort` (in, 1): synchronous abort of the current batch.
- `prog_mask` (in, 3): bit i enables problem i. Captured when `go` is accepted.
- `core_done` (in, 1): the core's `pc_done_flag`.
- `start` (out, 1): registered one-cycle pulse to the core (clears PC and done flag).
- `problem` (out, 2): problem code driven to the core.
- `busy` (out, 1): high whenever not in IDLE.
- `batch_done` (out, 1): one-cycle pulse when a batch completes normally.
- `result_valid` (out, 1): one-cycle pulse per finished program.
- `result_prog` (out, 2): problem code of the result being reported.
- `result_cycles` (out, CNT_W): RUN cycles consumed by that program.
- `result_timeout` (out, 1): the reported program hit TIMEOUT.
- `timeout_err` (out, 1): sticky flag; any program in the batch timed out.

## Operation

**States:** IDLE, SELECT, LAUNCH, SETTLE, RUN, REPORT, FINISH.

- **IDLE.** When `go`=1, capture `prog_mask` into the pending mask, clear `timeout_err`, go to SELECT. `go` in any other state is ignored.
- **SELECT.**
  - Pending mask nonzero: latch the lowest set bit index into `problem`, clear that bit, go to LAUNCH.
  - Pending mask zero: go to FINISH.
- **LAUNCH.** `start`=1 for exactly this cycle, then go to SETTLE.
- **SETTLE.** One cycle with `core_done` ignored, so a stale done from the previous program is never seen. Clear the counter, go to RUN.
- **RUN.** Counter increments every cycle.
  - Leave to REPORT on `core_done`=1, or when the counter reaches TIMEOUT.
  - If both occur in the same cycle, done wins and `result_timeout`=0.
- **REPORT.**
  - Pulse `result_valid` with `result_prog`=`problem`, `result_cycles`=counter value, `result_timeout`.
  - Set `timeout_err` if timed out.
  - Go to SELECT.
- **FINISH.** Pulse `batch_done` for one cycle, go to IDLE.
- **Abort.** `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - No `batch_done`, no `result_valid` for the interrupted program.
  - `start` is never asserted as the abort takes effect.
  - `abort` has priority over every other transition.
- `problem` is never driven to 2'b11. It holds its value from SELECT through REPORT and keeps its last value while in IDLE.
- The counter never wraps, because TIMEOUT < 2^CNT_W.

## Timing

- **Reset values:** state IDLE; `start`=0, `problem`=0, `busy`=0, `batch_done`=0, `result_valid`=0, `result_prog`=0, `result_cycles`=0, `result_timeout`=0, `timeout_err`=0, pending mask 0.
  - Reset mid-run returns to IDLE immediately. No pulse is emitted.
- **Batch start:** `go` sampled at edge 0.
  - Edge 1: SELECT.
  - Edge 2: LAUNCH, `start`=1.
  - Edge 3: SETTLE.
  - Edge 4: first RUN cycle.
- **Cycle count:** if `core_done` is first sampled high in the k-th RUN cycle, `result_valid`=1 in the following cycle with `result_cycles`=k (k ≥ 1).
- **Timeout:** after TIMEOUT RUN cycles with `core_done` low, REPORT follows with `result_cycles`=TIMEOUT and `result_timeout`=1.
- **Per-program overhead:** 4 cycles outside RUN (SELECT, LAUNCH, SETTLE, REPORT).
- **Empty mask:** `go` then SELECT then FINISH. `batch_done` is high in the 2nd cycle after `go` is sampled.
- **Glitch-free start:** `start` is a flop output. The core uses it as an asynchronous clear, so it must be glitch-free.
- **Result fields:** all result outputs change only on entry to REPORT and hold their values until the next REPORT.

## Test plan

1. **Single program.** `prog_mask`=3'b001, core model raises done 50 cycles after `start` → one `start` pulse, `problem`=0, `result_valid` once with `result_cycles`=49 (counted from first RUN cycle), `batch_done` 2 cycles after REPORT, `timeout_err`=0.
2. **Full batch.** `prog_mask`=3'b111, done latencies 119/106/82 → results in order prog 0,1,2, three `start` pulses, each `result_cycles` = latency − 1, exactly one `batch_done`.
3. **Timeout.** TIMEOUT=20, `prog_mask`=3'b010, `core_done` stuck 0 → `result_cycles`=20, `result_timeout`=1, `timeout_err`=1 sticky until next `go`, `batch_done` still pulses.
4. **Stale done / empty mask.** `core_done` held 1 across LAUNCH/SETTLE with mask 3'b100 → `result_cycles`=1, not 0. Separately, mask 0 → `batch_done` only, no `start`.
5. **Abort and ignored go.** `go` during RUN is ignored. `abort` in the 10th RUN cycle → IDLE next cycle, `busy`=0, no `result_valid`, no `batch_done`.
6. **Async reset.** `Reset` asserted mid-RUN, between clock edges → all outputs at reset values immediately. A subsequent `go` runs normally.
